// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two valid/ready write sources plus the registered
// register-file write port.
// The slave modport is the arbiter. The master modport is the surrounding
// pipeline, which drives both sources and observes the write port.
interface regfile_wb_arbiter_if;
    // Source A: ALU/immediate path
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;

    // Source B: load/multiply-divide path
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;

    // Register-file write port
    logic        WriteReg;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic        last_b;

    modport slave (
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  b_valid, b_addr, b_data,
        output b_ready,
        output WriteReg, wAddr, wData, last_b
    );

    modport master (
        output a_valid, a_addr, a_data,
        input  a_ready,
        output b_valid, b_addr, b_data,
        input  b_ready,
        input  WriteReg, wAddr, wData, last_b
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two sources share one write port. A has fixed priority. B is forced through
// after MAX_WAIT consecutive losses.
// One write is registered per cycle and launched on posedge, so it is stable
// when the register file samples it on the falling edge.
// Optional macro WBARB_DROP_R0_EN: writes to r0 are accepted but never raise
// WriteReg.
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4  // legal range 1..7
) (
    input logic              clk,
    input logic              rst,  // asynchronous, active low
    regfile_wb_arbiter_if.slave bus
);

    localparam logic [2:0] MaxWait = 3'(MAX_WAIT);

    logic [2:0]  wait_cnt;  // consecutive cycles B was held off by A
    logic        aWin;
    logic        bWin;
    logic        xfer;
    logic        writeEn;
    logic [4:0]  winAddr;
    logic [31:0] winData;

    // Grant decision and winner selection; never grants both sources at once
    always_comb begin
        bWin        = bus.b_valid && (!bus.a_valid || (wait_cnt >= MaxWait));
        aWin        = bus.a_valid && !bWin;
        bus.a_ready = aWin;
        bus.b_ready = bWin;
        xfer        = aWin || bWin;
        winAddr     = bWin ? bus.b_addr : bus.a_addr;
        winData     = bWin ? bus.b_data : bus.a_data;
`ifdef WBARB_DROP_R0_EN
        // r0 writes complete the handshake but never reach the port
        writeEn     = xfer && (winAddr != 5'd0);
`else
        writeEn     = xfer;
`endif
    end

    // Starvation counter and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt     <= 3'd0;
            bus.WriteReg <= 1'b0;
            bus.wAddr    <= 5'd0;
            bus.wData    <= 32'd0;
            bus.last_b   <= 1'b0;
        end else begin
            if (aWin && bus.b_valid) begin
                if (wait_cnt != 3'd7) begin
                    wait_cnt <= wait_cnt + 3'd1;
                end
            end else begin
                wait_cnt <= 3'd0;
            end

            bus.WriteReg <= writeEn;
            // Address, data and source hold their last values between writes
            if (writeEn) begin
                bus.wAddr  <= winAddr;
                bus.wData  <= winData;
                bus.last_b <= bWin;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (MAX_WAIT = 4).
// Stimulus pushes each expected write into a queue; the negedge monitor pops
// and compares every write the DUT puts on the port.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        fromB;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    wr_t  expQ[$];
    logic [31:0] rf [32];

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_wr(input logic [4:0] addr, input logic [31:0] data, input logic fromB);
`ifdef WBARB_DROP_R0_EN
        if (addr != 5'd0) expQ.push_back('{addr: addr, data: data, fromB: fromB});
`else
        expQ.push_back('{addr: addr, data: data, fromB: fromB});
`endif
    endtask

    // One arbitration cycle: drive after posedge, check grants, queue expected write
    task automatic vec(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic ea, input logic eb);
        @(posedge clk);
        #1;
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
        #2;
        chk("a_ready", 32'(bus.a_ready), 32'(ea));
        chk("b_ready", 32'(bus.b_ready), 32'(eb));
        if (ea) push_wr(aa, ad, 1'b0);
        else if (eb) push_wr(ba, bd, 1'b1);
    endtask

    task automatic idle();
        vec(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Monitor and register-file model: commit on the falling edge
    always @(negedge clk) begin
        if (rst && bus.WriteReg) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write at %0t",
                         bus.wAddr, bus.wData, $time);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("wAddr", 32'(bus.wAddr), 32'(e.addr));
                chk("wData", bus.wData, e.data);
                chk("last_b", 32'(bus.last_b), 32'(e.fromB));
            end
            if (bus.wAddr != 5'd0) rf[bus.wAddr] = bus.wData;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int na;
        int nb;
        logic expB [10];
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        bus.a_valid = 1'b0; bus.a_addr = 5'd0; bus.a_data = 32'd0;
        bus.b_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 32'd0;

        // Power-on reset
        rst = 1'b0;
        #2;
        chk("rst_WriteReg", 32'(bus.WriteReg), 32'd0);
        chk("rst_wAddr", 32'(bus.wAddr), 32'd0);
        chk("rst_wData", bus.wData, 32'd0);
        chk("rst_last_b", 32'(bus.last_b), 32'd0);
        #20;
        rst = 1'b1;

        // A only, then idle: port drops WriteReg
        vec(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();
        chk("a_only_WriteReg", 32'(bus.WriteReg), 32'd1);
        chk("a_only_wAddr", 32'(bus.wAddr), 32'd5);
        @(posedge clk);
        #3;
        chk("idle_WriteReg", 32'(bus.WriteReg), 32'd0);
        chk("idle_wAddr_hold", 32'(bus.wAddr), 32'd5);

        // Contention: A x4 then B, repeated
        expB = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        na = 0;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            vec(1'b1, 5'd1, 32'hA0 + 32'(na), 1'b1, 5'd2, 32'hB0 + 32'(nb), !expB[i], expB[i]);
            if (expB[i]) nb++;
            else na++;
        end
        idle();

        // B alone after two losses, then the counter restarts from zero
        vec(1'b1, 5'd3, 32'h300, 1'b1, 5'd4, 32'h400, 1'b1, 1'b0);
        vec(1'b1, 5'd3, 32'h301, 1'b1, 5'd4, 32'h400, 1'b1, 1'b0);
        vec(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h400, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vec(1'b1, 5'd3, 32'h310 + 32'(i), 1'b1, 5'd4, 32'h410,
                (i != 4), (i == 4));
        end
        idle();

        // Same address from both sources: grant order is commit order
        vec(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b1, 1'b0);
        vec(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        #1;
        chk("r7_final", rf[7], 32'h22);

        // r0 write
        vec(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();
`ifdef WBARB_DROP_R0_EN
        chk("r0_WriteReg", 32'(bus.WriteReg), 32'd0);
`else
        chk("r0_WriteReg", 32'(bus.WriteReg), 32'd1);
        chk("r0_wAddr", 32'(bus.wAddr), 32'd0);
`endif

        // Mid-stream reset with both sources still requesting
        vec(1'b1, 5'd9, 32'h900, 1'b1, 5'd10, 32'hA00, 1'b1, 1'b0);
        vec(1'b1, 5'd9, 32'h901, 1'b1, 5'd10, 32'hA00, 1'b1, 1'b0);
        @(posedge clk);
        #7;
        rst = 1'b0;
        #1;
        chk("mid_rst_WriteReg", 32'(bus.WriteReg), 32'd0);
        chk("mid_rst_wAddr", 32'(bus.wAddr), 32'd0);
        chk("mid_rst_wData", bus.wData, 32'd0);
        chk("mid_rst_last_b", 32'(bus.last_b), 32'd0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #12;
        rst = 1'b1;
        // Counter restarts from zero: B waits the full four A grants
        for (int i = 0; i < 5; i++) begin
            vec(1'b1, 5'd9, 32'h910 + 32'(i), 1'b1, 5'd10, 32'hA00,
                (i != 4), (i == 4));
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
